// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC, instruction memory with program loader, next-PC select
// and LOAD/RUN/HALT control. Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects.
module instruction_fetch #(
  parameter int                          PC_SIZE          = 32,
  parameter int                          INSTRUCTION_SIZE = 32,
  parameter int                          MEM_DEPTH        = 256,
  parameter logic [INSTRUCTION_SIZE-1:0] HALT_WORD        = 32'hFFFF_FFFF
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_stall,
  input  logic                        i_jump,
  input  logic [PC_SIZE-1:0]          i_jump_addr,
  input  logic                        i_branch,
  input  logic [PC_SIZE-1:0]          i_branch_addr,
  input  logic                        i_start,
  input  logic                        i_restart,
  input  logic                        i_wr_en,
  input  logic [INSTRUCTION_SIZE-1:0] i_wr_data,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic [PC_SIZE-1:0]          o_next_seq_pc,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic                        o_running,
  output logic                        o_halt,
  output logic                        o_mem_full,
  output logic                        o_misaligned
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [PC_SIZE-1:0]          pc_q, pc_d;
  logic [AW:0]                 wptr_q, wptr_d;
  logic [INSTRUCTION_SIZE-1:0] mem [MEM_DEPTH];

  logic                        mem_full;
  logic                        mem_we;
  logic                        advance;
  logic                        redirect;
  logic                        in_range;
  logic [PC_SIZE-1:0]          target;
  logic [PC_SIZE-1:0]          word_index;
  logic [INSTRUCTION_SIZE-1:0] fetch_word;

  assign mem_full   = (wptr_q == (AW+1)'(MEM_DEPTH));
  assign word_index = pc_q >> 2;
  assign in_range   = (word_index < PC_SIZE'(MEM_DEPTH));
  // Fetches past the end of memory read as the halt word so a runaway PC stops the core.
  assign fetch_word = in_range ? mem[pc_q[AW+1:2]] : HALT_WORD;

  assign advance  = (state_q == S_RUN) && i_enable && !i_stall;
  assign redirect = i_branch || i_jump;
  assign target   = i_branch ? i_branch_addr : i_jump_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  assign o_misaligned = misaligned_q;
`else
  assign o_misaligned = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    mem_we  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    if (i_restart) begin
      state_d = S_LOAD;
      pc_d    = '0;
      wptr_d  = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (i_wr_en && !mem_full) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + 1'b1;
          end
          if (i_start) begin
            state_d = S_RUN;
            pc_d    = '0;
          end
        end
        S_RUN: begin
          if (advance) begin
            // A redirect outranks the halt word: the halt was fetched on the wrong path.
            if (redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
              if (target[1:0] != 2'b00) begin
                state_d      = S_HALT;
                misaligned_d = 1'b1;
              end else begin
                pc_d = target;
              end
`else
              pc_d = target & ~PC_SIZE'(3);
`endif
            end else if (fetch_word == HALT_WORD) begin
              state_d = S_HALT;
            end else begin
              pc_d = pc_q + PC_SIZE'(4);
            end
          end
        end
        S_HALT: ;
        default: state_d = S_LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_LOAD;
      pc_q    <= '0;
      wptr_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wptr_q  <= wptr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // NOTE: the memory array has no reset; a loaded program must survive reset and restart.
  always_ff @(posedge i_clk) begin
    if (mem_we && i_reset) begin
      mem[wptr_q[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_instruction = (state_q == S_LOAD) ? '0 : fetch_word;
  assign o_next_seq_pc = pc_q + PC_SIZE'(4);
  assign o_pc          = pc_q;
  assign o_running     = (state_q == S_RUN);
  assign o_halt        = (state_q == S_HALT);
  assign o_mem_full    = mem_full;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural model predicts each cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_instruction_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam int          LOADING = 0, RUNNING = 1, HALTED = 2;

  typedef struct {
    logic        rst_n, en, stall, jump, branch, start, restart, wr_en;
    logic [31:0] jaddr, baddr, wdata;
  } stim_t;

  typedef struct {
    logic [31:0] pc, instr, nsp;
    logic        running, halt, full, mis;
    int          cyc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b0, i_stall = 1'b0, i_jump = 1'b0, i_branch = 1'b0;
  logic [31:0] i_jump_addr = '0, i_branch_addr = '0, i_wr_data = '0;
  logic        i_start = 1'b0, i_restart = 1'b0, i_wr_en = 1'b0;
  logic [31:0] o_instruction, o_next_seq_pc, o_pc;
  logic        o_running, o_halt, o_mem_full, o_misaligned;

  instruction_fetch #(
    .PC_SIZE(32), .INSTRUCTION_SIZE(32), .MEM_DEPTH(DEPTH), .HALT_WORD(HALT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_branch(i_branch),
    .i_branch_addr(i_branch_addr), .i_start(i_start), .i_restart(i_restart),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .o_instruction(o_instruction),
    .o_next_seq_pc(o_next_seq_pc), .o_pc(o_pc), .o_running(o_running), .o_halt(o_halt),
    .o_mem_full(o_mem_full), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  task automatic check(string name, int c, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode = LOADING;
  logic [31:0] m_pc   = '0;
  int          m_wptr = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_mis  = 1'b0;

  function automatic logic [31:0] m_fetch();
    if (m_pc / 4 < DEPTH) return m_mem[m_pc / 4];
    return HALT;
  endfunction

  task automatic m_clear();
    m_mode = LOADING;
    m_pc   = '0;
    m_wptr = 0;
    m_mis  = 1'b0;
  endtask

  task automatic m_step(stim_t s);
    logic [31:0] tgt;
    if (s.restart) begin
      m_clear();
      return;
    end
    case (m_mode)
      LOADING: begin
        if (s.wr_en && m_wptr < DEPTH) begin
          m_mem[m_wptr] = s.wdata;
          m_wptr++;
        end
        if (s.start) begin
          m_mode = RUNNING;
          m_pc   = '0;
        end
      end
      RUNNING: if (s.en && !s.stall) begin
        if (s.branch || s.jump) begin
          tgt = s.branch ? s.baddr : s.jaddr;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (tgt % 4 != 0) begin
            m_mis  = 1'b1;
            m_mode = HALTED;
          end else m_pc = tgt;
`else
          m_pc = tgt - (tgt % 4);
`endif
        end else if (m_fetch() == HALT) m_mode = HALTED;
        else m_pc = m_pc + 32'd4;
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic cycle(stim_t s);
    exp_t e;
    i_reset = s.rst_n; i_enable = s.en; i_stall = s.stall;
    i_jump = s.jump; i_jump_addr = s.jaddr; i_branch = s.branch; i_branch_addr = s.baddr;
    i_start = s.start; i_restart = s.restart; i_wr_en = s.wr_en; i_wr_data = s.wdata;
    if (!s.rst_n) m_clear();
    e.pc      = m_pc;
    e.instr   = (m_mode == LOADING) ? 32'd0 : m_fetch();
    e.nsp     = m_pc + 32'd4;
    e.running = (m_mode == RUNNING);
    e.halt    = (m_mode == HALTED);
    e.full    = (m_wptr == DEPTH);
    e.mis     = m_mis;
    e.cyc     = cyc;
    exp_q.push_back(e);
    @(posedge i_clk);
    if (s.rst_n) m_step(s);
    cyc++;
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, en: 1'b1, stall: 1'b0, jump: 1'b0, branch: 1'b0, start: 1'b0,
          restart: 1'b0, wr_en: 1'b0, jaddr: 32'd0, baddr: 32'd0, wdata: 32'd0};
    return s;
  endfunction

  task automatic write_word(logic [31:0] w);
    stim_t s;
    s = idle(); s.wr_en = 1'b1; s.wdata = w;
    cycle(s);
  endtask

  task automatic pulse_start();
    stim_t s;
    s = idle(); s.start = 1'b1;
    cycle(s);
  endtask

  task automatic pulse_restart();
    stim_t s;
    s = idle(); s.restart = 1'b1;
    cycle(s);
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) cycle(idle());
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc",         mon_e.cyc, o_pc,                   mon_e.pc);
      check("instruction", mon_e.cyc, o_instruction,         mon_e.instr);
      check("next_seq_pc", mon_e.cyc, o_next_seq_pc,         mon_e.nsp);
      check("running",    mon_e.cyc, {31'd0, o_running},     {31'd0, mon_e.running});
      check("halt",       mon_e.cyc, {31'd0, o_halt},        {31'd0, mon_e.halt});
      check("mem_full",   mon_e.cyc, {31'd0, o_mem_full},    {31'd0, mon_e.full});
      check("misaligned", mon_e.cyc, {31'd0, o_misaligned},  {31'd0, mon_e.mis});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    int    guard;
    @(posedge i_clk);
    #1;

    // Reset held low, then load the three-word program and run it to the halt.
    s = idle(); s.rst_n = 1'b0;
    cycle(s); cycle(s);
    idle_n(1);
    write_word(32'h2001_0005);
    write_word(32'h2002_0007);
    write_word(HALT);
    pulse_start();
    idle_n(5);

    // Restart, rerun; stall and disable at PC=4, then restart+start together at PC=8.
    pulse_restart();
    pulse_start();
    idle_n(1);
    s = idle(); s.stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle(s);
    s = idle(); s.en = 1'b0;
    for (int i = 0; i < 3; i++) cycle(s);
    idle_n(1);
    s = idle(); s.restart = 1'b1; s.start = 1'b1;
    cycle(s);
    idle_n(1);

    // Branch beats jump; a redirect on the halt word cancels the halt.
    pulse_start();
    s = idle(); s.branch = 1'b1; s.baddr = 32'h40; s.jump = 1'b1; s.jaddr = 32'h80;
    cycle(s);
    s = idle(); s.jump = 1'b1; s.jaddr = 32'h04;
    cycle(s);
    idle_n(3);

    // Loader boundaries: five writes into four words, RUN-time writes ignored, run off the end.
    pulse_restart();
    write_word(32'h1111_1111);
    write_word(32'h2222_2222);
    write_word(32'h3333_3333);
    write_word(32'h4444_4444);
    write_word(32'h5555_5555);
    s = idle(); s.start = 1'b1; s.wr_en = 1'b1; s.wdata = 32'hDEAD_0000;
    cycle(s);
    for (int i = 0; i < 7; i++) begin
      s = idle(); s.wr_en = 1'b1; s.wdata = HALT;
      cycle(s);
    end

    // Start with a write in the same cycle, then a misaligned jump.
    pulse_restart();
    s = idle(); s.start = 1'b1; s.wr_en = 1'b1; s.wdata = 32'h2001_0005;
    cycle(s);
    s = idle(); s.jump = 1'b1; s.jaddr = 32'h06;
    cycle(s);
    idle_n(2);

    // Asynchronous reset in the middle of a run.
    pulse_restart();
    pulse_start();
    idle_n(2);
    s = idle(); s.rst_n = 1'b0;
    cycle(s);
    idle_n(2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst_n   = ($urandom_range(0, 299) != 0);
      s.en      = ($urandom_range(0, 7) != 0);
      s.stall   = ($urandom_range(0, 4) == 0);
      s.jump    = ($urandom_range(0, 5) == 0);
      s.branch  = ($urandom_range(0, 7) == 0);
      s.start   = ($urandom_range(0, 9) == 0);
      s.restart = ($urandom_range(0, 39) == 0);
      s.wr_en   = ($urandom_range(0, 2) == 0);
      s.wdata   = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
      s.jaddr   = 32'($urandom_range(0, 7) * 4);
      s.baddr   = 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 5) == 0) s.jaddr = s.jaddr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) s.baddr = s.baddr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 40) == 0) s.jaddr = 32'hFFFF_FFFC;
      cycle(s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge i_clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
